// File: rtl/decoder10_rr_sched.sv
// ---------------------------------------------------------------------------
// decoder10_rr_sched
//
// Purpose:
//   Round-robin scheduler that shares one decoder10 among up to N_REQ
//   requesters. A winner is chosen round-robin among the valid requests,
//   starting just after the most recently granted index. The scheduler then
//   drives the decoder's active-low enable (WD) and 4-bit select (A), so
//   exactly one decoder output is active per grant. The same grant is also
//   exported as a one-hot vector.
//
//   A grant is held for as long as the holder keeps its request high. When
//   the holder releases, the scheduler inserts one dead cycle (GAP) with
//   WD=1 before any new grant. This gives break-before-make on the decoder
//   outputs.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a hold counter forces the holder to release after
//   HOLD_MAX consecutive grant cycles, but only if another valid request
//   is pending. If no other request is pending, the counter saturates and
//   the grant is kept. When the macro is undefined, there is no counter
//   and HOLD_MAX is not used.
//
// Parameters:
//   N_REQ     requesters in use, 2..10 (req[9:N_REQ] ignored)
//   HOLD_MAX  max consecutive grant cycles under ARB_TIMEOUT_EN, >= 2
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   req    in  10   request per requester, level held while wanted
//   WD     out  1   decoder enable, active low
//   A      out  4   decoder select, 0..N_REQ-1
//   grant  out 10   one-hot grant, (1<<A) when WD==0, else 0
//   busy   out  1   high while a grant is active
// ---------------------------------------------------------------------------
module decoder10_rr_sched #(
  parameter int unsigned N_REQ    = 10,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req,
  output logic       WD,
  output logic [3:0] A,
  output logic [9:0] grant,
  output logic       busy
);

  if (N_REQ < 2 || N_REQ > 10 || HOLD_MAX < 2) begin : g_param_check
    $error("decoder10_rr_sched: N_REQ must be 2..10 and HOLD_MAX >= 2");
  end

  localparam logic [9:0] REQ_MASK = 10'((32'd1 << N_REQ) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_wd, w_wd_nxt;
  logic [3:0] r_a, w_a_nxt;
  logic [9:0] r_grant, w_grant_nxt;
  logic       r_busy, w_busy_nxt;
  logic [3:0] r_last, w_last_nxt;

  logic [9:0] w_req_v;
  logic       w_hold;
  logic       w_found;
  logic [3:0] w_pick;
  logic [3:0] w_start;
  logic       w_release;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned     CW       = $clog2(HOLD_MAX) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD_MAX - 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_other;
`endif

  // Requests outside the configured range never take part in arbitration.
  assign w_req_v = req & REQ_MASK;

  // r_grant is one-hot on the holder while granted, so masking the request
  // vector with it gives the holder's own request level.
  assign w_hold  = |(w_req_v & r_grant);
`ifdef ARB_TIMEOUT_EN
  assign w_other = |(w_req_v & ~r_grant);
`endif

  // Round-robin search. It starts just after the last granted index and
  // wraps at N_REQ-1. After a reset, last is 9, so the search starts at 0
  // for every legal N_REQ.
  always_comb begin
    logic [4:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    w_start = (r_last >= 4'(N_REQ - 1)) ? 4'd0 : r_last + 4'd1;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      v_idx = 5'(w_start) + 5'(k);
      if (v_idx >= 5'(N_REQ)) begin
        v_idx = v_idx - 5'(N_REQ);
      end
      if (!w_found && w_req_v[v_idx[3:0]]) begin
        w_found = 1'b1;
        w_pick  = v_idx[3:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_a_nxt     = r_a;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_last_nxt  = r_last;
    w_release   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif

    case (r_state)
      IDLE, GAP: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_wd_nxt    = 1'b0;
          w_a_nxt     = w_pick;
          w_grant_nxt = 10'd1 << w_pick;
          w_busy_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end

      GRANT: begin
        // A holder dropping its request always wins. A new request raised
        // in the same cycle is arbitrated in the GAP cycle.
        if (!w_hold) begin
          w_release = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          // Saturated: release only when somebody else is waiting.
          w_release = w_other;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
        if (w_release) begin
          // A keeps its value through GAP; only the enable and grant drop.
          w_state_nxt = GAP;
          w_wd_nxt    = 1'b1;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_last_nxt  = r_a;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_wd_nxt    = 1'b1;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wd    <= 1'b1;
      r_a     <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_last  <= 4'd9;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
      r_a     <= w_a_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_last  <= w_last_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign WD    = r_wd;
  assign A     = r_a;
  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

// File: tb/tb_decoder10_rr_sched.sv
module tb_decoder10_rr_sched;

  localparam int NR = 10;
  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] req = '0;
  logic       WD;
  logic [3:0] A;
  logic [9:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  decoder10_rr_sched #(
    .N_REQ    (NR),
    .HOLD_MAX (HM)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .WD    (WD),
    .A     (A),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model. It tracks only who holds the resource, who held it
  // last, and how long the current hold has lasted.
  int m_holder;
  int m_a;
  int m_last;
  int m_cnt;

  function automatic void m_reset();
    m_holder = -1;
    m_a      = 0;
    m_last   = NR - 1;
    m_cnt    = 0;
  endfunction

  function automatic void m_step(input logic [9:0] r);
    if (m_holder >= 0) begin
      bit rel;
      rel = (r[4'(m_holder)] == 1'b0);
`ifdef ARB_TIMEOUT_EN
      if (!rel) begin
        bit others;
        others = 1'b0;
        for (int i = 0; i < NR; i++)
          if (i != m_holder && r[4'(i)]) others = 1'b1;
        if (m_cnt == HM - 1) rel = others;
        else m_cnt++;
      end
`endif
      if (rel) begin
        m_last   = m_holder;
        m_holder = -1;
      end
    end else begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (r[4'(c)]) begin
          m_holder = c;
          m_a      = c;
          m_cnt    = 0;
          break;
        end
      end
    end
  endfunction

  typedef struct {
    logic       rst;
    logic [9:0] req;
    logic       wd;
    logic [3:0] a;
    logic [9:0] grant;
    logic       busy;
    string      name;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 10'h3FF, 1'b1, 4'd0, 10'h000, 1'b0, "t1_reset"};
    tbl[1]  = '{1'b0, 10'h3FF, 1'b0, 4'd0, 10'h001, 1'b1, "t1_first_grant"};
    tbl[2]  = '{1'b1, 10'h000, 1'b1, 4'd0, 10'h000, 1'b0, "t2_reset"};
    tbl[3]  = '{1'b0, 10'h024, 1'b0, 4'd2, 10'h004, 1'b1, "t2_grant2"};
    tbl[4]  = '{1'b0, 10'h020, 1'b1, 4'd2, 10'h000, 1'b0, "t2_gap"};
    tbl[5]  = '{1'b0, 10'h020, 1'b0, 4'd5, 10'h020, 1'b1, "t2_grant5"};
    tbl[6]  = '{1'b0, 10'h200, 1'b1, 4'd5, 10'h000, 1'b0, "t3_gap5"};
    tbl[7]  = '{1'b0, 10'h200, 1'b0, 4'd9, 10'h200, 1'b1, "t3_grant9"};
    tbl[8]  = '{1'b0, 10'h201, 1'b0, 4'd9, 10'h200, 1'b1, "t3_hold9"};
    tbl[9]  = '{1'b0, 10'h001, 1'b1, 4'd9, 10'h000, 1'b0, "t3_gap9"};
    tbl[10] = '{1'b0, 10'h001, 1'b0, 4'd0, 10'h001, 1'b1, "t3_wrap0"};
    tbl[11] = '{1'b0, 10'h002, 1'b1, 4'd0, 10'h000, 1'b0, "swap_gap"};
    tbl[12] = '{1'b0, 10'h002, 1'b0, 4'd1, 10'h002, 1'b1, "swap_grant1"};
    tbl[13] = '{1'b0, 10'h000, 1'b1, 4'd1, 10'h000, 1'b0, "drop_gap"};
    tbl[14] = '{1'b0, 10'h000, 1'b1, 4'd1, 10'h000, 1'b0, "drop_idle"};

    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      cycle();
      check({tbl[i].name, "_wd"},    32'(WD),    32'(tbl[i].wd));
      check({tbl[i].name, "_a"},     32'(A),     32'(tbl[i].a));
      check({tbl[i].name, "_grant"}, 32'(grant), 32'(tbl[i].grant));
      check({tbl[i].name, "_busy"},  32'(busy),  32'(tbl[i].busy));
    end

    // Requesters 3 and 7 both held
    rst = 1'b1; req = '0; cycle(); rst = 1'b0;
    req = 10'h088;
`ifdef ARB_TIMEOUT_EN
    begin
      int exp_seq[11];
      exp_seq = '{3, 3, 3, 3, -1, 7, 7, 7, 7, -1, 3};
      for (int c = 0; c < 11; c++) begin
        cycle();
        if (exp_seq[c] < 0) begin
          check("t4_gap_wd",    32'(WD),    32'd1);
          check("t4_gap_grant", 32'(grant), 32'd0);
        end else begin
          check("t4_wd", 32'(WD), 32'd0);
          check("t4_a",  32'(A),  32'(exp_seq[c]));
        end
      end
    end
`else
    for (int c = 0; c < 100; c++) begin
      cycle();
      check("t5_wd_held", 32'(WD), 32'd0);
      check("t5_a_held",  32'(A),  32'd3);
    end
`endif

    // Asynchronous reset while requester 6 holds the grant
    rst = 1'b1; req = '0; cycle(); rst = 1'b0;
    req = 10'h040;
    cycle();
    check("t6_grant6_a", 32'(A), 32'd6);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_wd",    32'(WD),    32'd1);
    check("t6_async_grant", 32'(grant), 32'd0);
    check("t6_async_a",     32'(A),     32'd0);
    check("t6_async_busy",  32'(busy),  32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    cycle();
    check("t6_regrant_a",     32'(A),     32'd6);
    check("t6_regrant_wd",    32'(WD),    32'd0);
    check("t6_regrant_grant", 32'(grant), 32'h040);

    // Randomized requests against the model
    rst = 1'b1; req = '0; cycle(); rst = 1'b0;
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [9:0] nr;
      logic [9:0] exp_g;
      bit         do_rst;
      nr = req;
      for (int b = 0; b < NR; b++)
        if ($urandom_range(7) == 0) nr[4'(b)] = ~nr[4'(b)];
      req    = nr;
      do_rst = ($urandom_range(299) == 0);
      if (do_rst) begin
        rst = 1'b1;
        m_reset();
      end else begin
        m_step(nr);
      end
      cycle();
      rst   = 1'b0;
      exp_g = (m_holder >= 0) ? (10'd1 << m_holder) : 10'd0;
      check("rnd_wd",    32'(WD),    32'(m_holder < 0));
      check("rnd_a",     32'(A),     32'(m_a));
      check("rnd_grant", 32'(grant), 32'(exp_g));
      check("rnd_busy",  32'(busy),  32'(m_holder >= 0));
      check("rnd_onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
